// File: rtl/regfile_writeback_buffer_if.sv
// Bundle of producer, commit, read-forwarding and status signals around the writeback buffer.
// No logic or latency of its own; carries signals only.
// Backpressure: in_ready (slave -> master) holds off producers.
interface regfile_writeback_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // producer side
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_reg;
  logic [DATA_W-1:0] in_data;
  // commit side
  logic              drain_en;
  logic [ADDR_W-1:0] WR;
  logic [DATA_W-1:0] WD;
  logic              RegWrite;
  // read path
  logic [ADDR_W-1:0] RR1;
  logic [ADDR_W-1:0] RR2;
  logic [DATA_W-1:0] rf_rd1;
  logic [DATA_W-1:0] rf_rd2;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] RD2;
  // status
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;

  // buffer side
  modport slave (
    input  in_valid, in_reg, in_data, drain_en, RR1, RR2, rf_rd1, rf_rd2,
    output in_ready, WR, WD, RegWrite, RD1, RD2, count, empty, full
  );

  // producer / register-file side
  modport master (
    output in_valid, in_reg, in_data, drain_en, RR1, RR2, rf_rd1, rf_rd2,
    input  in_ready, WR, WD, RegWrite, RD1, RD2, count, empty, full
  );
endinterface

// File: rtl/regfile_writeback_buffer.sv
// In-order writeback FIFO in front of the register file, with read forwarding of pending results.
// Latency: a result enqueued at posedge N is presented for commit (RegWrite) during cycle N+1.
// Backpressure: in_ready = !full, independent of in_valid; a same-cycle pop does not reopen it.
module regfile_writeback_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  regfile_writeback_buffer_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] rg;
    logic [DATA_W-1:0] dat;
  } entry_t;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  entry_t             w_head;
  logic [PTR_W-1:0]   w_idx;
  logic [DATA_W-1:0]  w_rd1;
  logic [DATA_W-1:0]  w_rd2;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  // Register 0 is hardwired: such results are accepted but dropped.
  assign w_push  = bus.in_valid && !w_full && (bus.in_reg != '0);
  // Reset discards pending entries, so nothing commits during a reset cycle.
  assign w_pop   = !w_empty && bus.drain_en && !reset;
  assign w_head  = r_mem[r_rd_ptr];

  assign bus.in_ready = !w_full;
  assign bus.RegWrite = w_pop;
  assign bus.WR       = w_empty ? '0 : w_head.rg;
  assign bus.WD       = w_empty ? '0 : w_head.dat;
  assign bus.count    = r_count;
  assign bus.empty    = w_empty;
  assign bus.full     = w_full;
  assign bus.RD1      = w_rd1;
  assign bus.RD2      = w_rd2;

  // FIFO state: pointers, occupancy and entry storage.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= '{rg: bus.in_reg, dat: bus.in_data};
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Forwarding: walk entries oldest to newest so the newest match wins; head included.
  always_comb begin
    w_rd1 = bus.rf_rd1;
    w_rd2 = bus.rf_rd2;
    w_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rd_ptr + PTR_W'(i);
      if (CNT_W'(i) < r_count) begin
        if ((bus.RR1 != '0) && (r_mem[w_idx].rg == bus.RR1)) begin
          w_rd1 = r_mem[w_idx].dat;
        end
        if ((bus.RR2 != '0) && (r_mem[w_idx].rg == bus.RR2)) begin
          w_rd2 = r_mem[w_idx].dat;
        end
      end
    end
  end
endmodule

// File: tb/tb_regfile_writeback_buffer.sv
// Directed bench for the writeback buffer with a commit scoreboard.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// Expected commits are queued when a result is driven and popped when RegWrite is seen.
module tb_regfile_writeback_buffer;
  logic clock;
  logic reset;

  regfile_writeback_buffer_if bus ();

  regfile_writeback_buffer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [1:0]  rg;
    logic [15:0] dat;
  } sb_t;

  sb_t q[$];
  sb_t mon_e;
  int  checks    = 0;
  int  errors    = 0;
  int  n_commits = 0;

  localparam logic [15:0] RF1 = 16'h5A5A;
  localparam logic [15:0] RF2 = 16'hA5A5;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Drive one result for a cycle; nonzero destinations are expected to commit later.
  task automatic enq(input logic [1:0] r, input logic [15:0] d);
    bus.in_valid = 1'b1;
    bus.in_reg   = r;
    bus.in_data  = d;
    @(negedge clock);
    if (r != 2'd0) q.push_back('{rg: r, dat: d});
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
  endtask

  // Scoreboard: every commit must match the oldest expected result.
  always @(negedge clock) begin
    if (!reset && bus.RegWrite === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_commit", 32'(bus.RegWrite), 32'd0);
      end else begin
        mon_e = q.pop_front();
        n_commits++;
        chk("commit_WR", 32'(bus.WR), 32'(mon_e.rg));
        chk("commit_WD", 32'(bus.WD), 32'(mon_e.dat));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_reg   = 2'd1;
    bus.in_data  = 16'h0077;
    bus.drain_en = 1'b1;
    bus.RR1      = 2'd0;
    bus.RR2      = 2'd0;
    bus.rf_rd1   = RF1;
    bus.rf_rd2   = RF2;

    // Reset held two cycles with a producer asserting valid.
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_RegWrite", 32'(bus.RegWrite), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_WR", 32'(bus.WR), 32'd0);
    chk("rst_WD", 32'(bus.WD), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    @(posedge clock); #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;

    // Single write commits the cycle after enqueue.
    enq(2'd2, 16'h1234);
    @(negedge clock);
    chk("single_RegWrite", 32'(bus.RegWrite), 32'd1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("single_empty", 32'(bus.empty), 32'd1);
    chk("single_RegWrite_off", 32'(bus.RegWrite), 32'd0);

    // Fill while stalled, check forwarding of the newest duplicate.
    @(posedge clock); #1;
    bus.drain_en = 1'b0;
    bus.RR1      = 2'd1;
    bus.RR2      = 2'd2;
    enq(2'd1, 16'h000A);
    enq(2'd2, 16'h000B);
    enq(2'd3, 16'h000C);
    enq(2'd1, 16'h000D);
    @(negedge clock);
    chk("fill_count", 32'(bus.count), 32'd4);
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
    chk("fwd_RD1_newest", 32'(bus.RD1), 32'h000D);
    chk("fwd_RD2_reg2", 32'(bus.RD2), 32'h000B);
    bus.RR2 = 2'd3;
    #1;
    chk("fwd_RD2_reg3", 32'(bus.RD2), 32'h000C);
    // Full with a pop in the same cycle: in_ready stays low, the offered result is refused.
    @(posedge clock); #1;
    bus.drain_en = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_reg   = 2'd3;
    bus.in_data  = 16'h00EE;
    @(negedge clock);
    chk("full_pop_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_pop_RegWrite", 32'(bus.RegWrite), 32'd1);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    repeat (4) begin
      @(posedge clock); #1;
    end
    @(negedge clock);
    chk("drain_empty", 32'(bus.empty), 32'd1);
    chk("drain_sb_left", 32'(q.size()), 32'd0);
    chk("drain_RD1_rf", 32'(bus.RD1), 32'(RF1));

    // Register 0: accepted, never stored, never forwarded.
    @(posedge clock); #1;
    bus.RR1      = 2'd0;
    bus.in_valid = 1'b1;
    bus.in_reg   = 2'd0;
    bus.in_data  = 16'hFFFF;
    @(negedge clock);
    chk("r0_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    @(negedge clock);
    chk("r0_count", 32'(bus.count), 32'd0);
    chk("r0_RegWrite", 32'(bus.RegWrite), 32'd0);
    chk("r0_RD1", 32'(bus.RD1), 32'(RF1));

    // Simultaneous enqueue and commit keeps count steady while pointers wrap.
    @(posedge clock); #1;
    bus.drain_en = 1'b0;
    enq(2'd1, 16'h0011);
    enq(2'd2, 16'h0022);
    @(negedge clock);
    chk("sim_count_start", 32'(bus.count), 32'd2);
    @(posedge clock); #1;
    bus.drain_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_reg   = 2'((i % 3) + 1);
      bus.in_data  = 16'(16'h0100 + i);
      @(negedge clock);
      q.push_back('{rg: 2'((i % 3) + 1), dat: 16'(16'h0100 + i)});
      chk("sim_count", 32'(bus.count), 32'd2);
      @(posedge clock); #1;
    end
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
    end
    @(negedge clock);
    chk("sim_count_end", 32'(bus.count), 32'd0);
    chk("sim_sb_left", 32'(q.size()), 32'd0);

    // Reset in the middle of a drain discards what is left.
    @(posedge clock); #1;
    bus.drain_en = 1'b0;
    bus.RR1      = 2'd1;
    bus.RR2      = 2'd2;
    enq(2'd1, 16'h0031);
    enq(2'd2, 16'h0032);
    enq(2'd3, 16'h0033);
    @(negedge clock);
    chk("mid_count", 32'(bus.count), 32'd3);
    chk("mid_RD1", 32'(bus.RD1), 32'h0031);
    chk("mid_RD2", 32'(bus.RD2), 32'h0032);
    @(posedge clock); #1;
    bus.drain_en = 1'b1;
    bus.RR1      = 2'd3;
    @(posedge clock); #1;
    reset = 1'b1;
    q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_RD1", 32'(bus.RD1), 32'(RF1));
    chk("post_rst_RD2", 32'(bus.RD2), 32'(RF2));
    chk("post_rst_count", 32'(bus.count), 32'd0);
    chk("post_rst_RegWrite", 32'(bus.RegWrite), 32'd0);
    chk("post_rst_WR", 32'(bus.WR), 32'd0);
    repeat (3) begin
      @(posedge clock); #1;
    end
    chk("total_commits", 32'(n_commits), 32'd13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
